// File: rtl/dmi_host_arbiter.sv
// N-host round-robin front end for a single Debug Module DMI port.
// One transaction in flight, response timeout and per-host clear/abort.
module dmi_host_arbiter #(
  parameter int NumHosts      = 2,
  parameter int AddrWidth     = 7,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 1024,
  localparam int IdW          = (NumHosts > 1) ? $clog2(NumHosts) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NumHosts-1:0]            host_clear_i,
  input  logic [NumHosts-1:0]            host_req_valid_i,
  output logic [NumHosts-1:0]            host_req_ready_o,
  input  logic [NumHosts*AddrWidth-1:0]  host_req_addr_i,
  input  logic [NumHosts*DataWidth-1:0]  host_req_data_i,
  input  logic [NumHosts*2-1:0]          host_req_op_i,
  output logic [NumHosts-1:0]            host_resp_valid_o,
  input  logic [NumHosts-1:0]            host_resp_ready_i,
  output logic [DataWidth-1:0]           host_resp_data_o,
  output logic [1:0]                     host_resp_resp_o,
  output logic                           dmi_clear_o,
  output logic                           dmi_req_valid_o,
  input  logic                           dmi_req_ready_i,
  output logic [AddrWidth-1:0]           dmi_req_addr_o,
  output logic [DataWidth-1:0]           dmi_req_data_o,
  output logic [1:0]                     dmi_req_op_o,
  input  logic                           dmi_resp_valid_i,
  output logic                           dmi_resp_ready_o,
  input  logic [DataWidth-1:0]           dmi_resp_data_i,
  input  logic [1:0]                     dmi_resp_resp_i,
  output logic [IdW-1:0]                 grant_id_o,
  output logic                           timeout_o
);

  localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  state_e                state_r;
  logic [IdW-1:0]        ptr_r;
  logic [IdW-1:0]        grant_r;
  logic [AddrWidth-1:0]  addr_r;
  logic [DataWidth-1:0]  data_r;
  logic [1:0]            op_r;
  logic [DataWidth-1:0]  resp_data_r;
  logic [1:0]            resp_code_r;
  logic [CntW-1:0]       cnt_r;
  logic                  req_valid_r;
  logic [NumHosts-1:0]   resp_valid_r;
  logic                  clear_r;
  logic                  timeout_r;

  int                    idx_s;
  logic [IdW-1:0]        cand_s;
  logic [IdW-1:0]        winner_s;
  logic                  found_s;
  logic [AddrWidth-1:0]  win_addr_s;
  logic [DataWidth-1:0]  win_data_s;
  logic [1:0]            win_op_s;
  logic                  grant_clear_s;
  logic [NumHosts-1:0]   grant_onehot_s;

  // Round-robin search from the pointer upward with wrap, then payload mux.
  always_comb begin
    found_s    = 1'b0;
    winner_s   = '0;
    idx_s      = 0;
    cand_s     = '0;
    win_addr_s = '0;
    win_data_s = '0;
    win_op_s   = 2'd0;
    for (int i = 0; i < NumHosts; i++) begin
      idx_s = int'(ptr_r) + i;
      if (idx_s >= NumHosts) begin
        idx_s = idx_s - NumHosts;
      end else begin
        idx_s = idx_s;
      end
      cand_s = IdW'(idx_s);
      if (!found_s && host_req_valid_i[cand_s]) begin
        found_s  = 1'b1;
        winner_s = cand_s;
      end else begin
        found_s  = found_s;
      end
    end
    for (int k = 0; k < NumHosts; k++) begin
      if (winner_s == IdW'(k)) begin
        win_addr_s = host_req_addr_i[k*AddrWidth +: AddrWidth];
        win_data_s = host_req_data_i[k*DataWidth +: DataWidth];
        win_op_s   = host_req_op_i[k*2 +: 2];
      end else begin
        win_addr_s = win_addr_s;
      end
    end
  end

  assign grant_clear_s  = host_clear_i[grant_r];
  assign grant_onehot_s = NumHosts'(1) << grant_r;

  // Accept is combinational in IDLE; both ready outputs are held low while in reset.
  assign host_req_ready_o  = (state_r == ST_IDLE && found_s && !rst_i) ? (NumHosts'(1) << winner_s) : '0;
  assign dmi_resp_ready_o  = !rst_i && (state_r == ST_IDLE || state_r == ST_WAIT);
  assign host_resp_valid_o = resp_valid_r;
  assign host_resp_data_o  = resp_data_r;
  assign host_resp_resp_o  = resp_code_r;
  assign dmi_clear_o       = clear_r;
  assign dmi_req_valid_o   = req_valid_r;
  assign dmi_req_addr_o    = addr_r;
  assign dmi_req_data_o    = data_r;
  assign dmi_req_op_o      = op_r;
  assign grant_id_o        = grant_r;
  assign timeout_o         = timeout_r;

  // Transaction FSM with all registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r      <= ST_IDLE;
      ptr_r        <= '0;
      grant_r      <= '0;
      addr_r       <= '0;
      data_r       <= '0;
      op_r         <= 2'd0;
      resp_data_r  <= '0;
      resp_code_r  <= 2'd0;
      cnt_r        <= '0;
      req_valid_r  <= 1'b0;
      resp_valid_r <= '0;
      clear_r      <= 1'b0;
      timeout_r    <= 1'b0;
    end else begin
      clear_r   <= 1'b0;
      timeout_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          clear_r <= |host_clear_i;
          if (found_s) begin
            addr_r      <= win_addr_s;
            data_r      <= win_data_s;
            op_r        <= win_op_s;
            grant_r     <= winner_s;
            req_valid_r <= 1'b1;
            state_r     <= ST_REQ;
          end else begin
            state_r     <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (grant_clear_s) begin
            req_valid_r <= 1'b0;
            clear_r     <= 1'b1;
            state_r     <= ST_IDLE;
          end else if (dmi_req_ready_i) begin
            req_valid_r <= 1'b0;
            cnt_r       <= '0;
            state_r     <= ST_WAIT;
          end else begin
            state_r     <= ST_REQ;
          end
        end
        ST_WAIT: begin
          if (grant_clear_s) begin
            clear_r      <= 1'b1;
            state_r      <= ST_IDLE;
          end else if (dmi_resp_valid_i) begin
            resp_data_r  <= dmi_resp_data_i;
            resp_code_r  <= dmi_resp_resp_i;
            resp_valid_r <= grant_onehot_s;
            state_r      <= ST_RESP;
          end else if (TimeoutCycles != 0 && cnt_r == CntLast) begin
            resp_data_r  <= '0;
            resp_code_r  <= 2'd2;
            resp_valid_r <= grant_onehot_s;
            timeout_r    <= 1'b1;
            clear_r      <= 1'b1;
            state_r      <= ST_RESP;
          end else begin
            cnt_r        <= cnt_r + 1'b1;
          end
        end
        ST_RESP: begin
          if (grant_clear_s) begin
            resp_valid_r <= '0;
            clear_r      <= 1'b1;
            state_r      <= ST_IDLE;
          end else if (host_resp_ready_i[grant_r]) begin
            resp_valid_r <= '0;
            state_r      <= ST_IDLE;
            if (grant_r == IdW'(NumHosts - 1)) begin
              ptr_r <= '0;
            end else begin
              ptr_r <= grant_r + 1'b1;
            end
          end else begin
            state_r      <= ST_RESP;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmi_host_arbiter.sv
// Directed bench for dmi_host_arbiter: 3 hosts, 8-cycle timeout.
module tb_dmi_host_arbiter;

  localparam int NH = 3;
  localparam int AW = 7;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NH-1:0]     host_clear = '0;
  logic [NH-1:0]     req_valid = '0;
  logic [NH-1:0]     req_ready;
  logic [NH*AW-1:0]  req_addr = '0;
  logic [NH*DW-1:0]  req_data = '0;
  logic [NH*2-1:0]   req_op = '0;
  logic [NH-1:0]     resp_valid;
  logic [NH-1:0]     resp_ready = '0;
  logic [DW-1:0]     resp_data;
  logic [1:0]        resp_code;
  logic              dmi_clear;
  logic              dmi_req_valid;
  logic              dmi_req_ready = 1'b0;
  logic [AW-1:0]     dmi_req_addr;
  logic [DW-1:0]     dmi_req_data;
  logic [1:0]        dmi_req_op;
  logic              dmi_resp_valid = 1'b0;
  logic              dmi_resp_ready;
  logic [DW-1:0]     dmi_resp_data = '0;
  logic [1:0]        dmi_resp_resp = 2'd0;
  logic [1:0]        grant_id;
  logic              timeout;

  int n_vec = 0;
  int n_miscompare = 0;

  dmi_host_arbiter #(
    .NumHosts(NH), .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(8)
  ) dut (
    .clk_i(clk), .rst_i(rst), .host_clear_i(host_clear),
    .host_req_valid_i(req_valid), .host_req_ready_o(req_ready),
    .host_req_addr_i(req_addr), .host_req_data_i(req_data), .host_req_op_i(req_op),
    .host_resp_valid_o(resp_valid), .host_resp_ready_i(resp_ready),
    .host_resp_data_o(resp_data), .host_resp_resp_o(resp_code),
    .dmi_clear_o(dmi_clear), .dmi_req_valid_o(dmi_req_valid), .dmi_req_ready_i(dmi_req_ready),
    .dmi_req_addr_o(dmi_req_addr), .dmi_req_data_o(dmi_req_data), .dmi_req_op_o(dmi_req_op),
    .dmi_resp_valid_i(dmi_resp_valid), .dmi_resp_ready_o(dmi_resp_ready),
    .dmi_resp_data_i(dmi_resp_data), .dmi_resp_resp_i(dmi_resp_resp),
    .grant_id_o(grant_id), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscompare++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset: outputs low even with a host requesting.
    rst = 1'b1;
    req_valid = 3'b001;
    #2;
    check_vec("rst_req_ready", req_ready, 0);
    check_vec("rst_dmi_resp_ready", dmi_resp_ready, 0);
    check_vec("rst_dmi_req_valid", dmi_req_valid, 0);
    check_vec("rst_grant", grant_id, 0);
    check_vec("rst_resp_valid", resp_valid, 0);
    check_vec("rst_clear_timeout", {dmi_clear, timeout}, 0);
    req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Single host 0 read of 0x11.
    req_valid = 3'b001;
    req_addr[0*AW +: AW] = 7'h11;
    req_op[1:0] = 2'd1;
    #1;
    check_vec("t1_accept_c0", req_ready, 3'b001);
    tick();
    req_valid = '0;
    check_vec("t1_req_valid_c1", dmi_req_valid, 1);
    check_vec("t1_addr", dmi_req_addr, 7'h11);
    check_vec("t1_op", dmi_req_op, 1);
    check_vec("t1_grant", grant_id, 0);
    dmi_req_ready = 1'b1;
    tick();
    dmi_req_ready = 1'b0;
    check_vec("t1_req_dropped", dmi_req_valid, 0);
    check_vec("t1_wait_resp_ready", dmi_resp_ready, 1);
    tick();
    dmi_resp_valid = 1'b1;
    dmi_resp_data = 32'hCAFEF00D;
    dmi_resp_resp = 2'd0;
    #1;
    check_vec("t1_no_resp_yet", resp_valid, 0);
    tick();
    dmi_resp_valid = 1'b0;
    check_vec("t1_resp_valid", resp_valid, 3'b001);
    check_vec("t1_resp_data", resp_data, 32'hCAFEF00D);
    check_vec("t1_resp_code", resp_code, 0);
    tick();
    check_vec("t1_resp_held", resp_valid, 3'b001);
    resp_ready = 3'b001;
    tick();
    resp_ready = '0;
    check_vec("t1_resp_done", resp_valid, 0);

    // Host 0 granted (pointer at 1), DM stalls 5 cycles; host 1 waits.
    req_valid = 3'b001;
    req_addr[0*AW +: AW] = 7'h05;
    req_data[0*DW +: DW] = 32'h12345678;
    req_op[1:0] = 2'd2;
    #1;
    check_vec("st_accept", req_ready, 3'b001);
    tick();
    req_valid = 3'b010;
    req_addr[0*AW +: AW] = 7'h7F;
    req_data[0*DW +: DW] = 32'hFFFFFFFF;
    for (int c = 0; c < 5; c++) begin
      #1;
      check_vec("st_valid_held", dmi_req_valid, 1);
      check_vec("st_payload", {dmi_req_addr, dmi_req_data, dmi_req_op}, {7'h05, 32'h12345678, 2'd2});
      check_vec("st_no_accept", req_ready, 0);
      tick();
    end
    dmi_req_ready = 1'b1;
    tick();
    dmi_req_ready = 1'b0;
    dmi_resp_valid = 1'b1;
    dmi_resp_data = 32'h0;
    #1;
    check_vec("st_wait_no_accept", req_ready, 0);
    tick();
    dmi_resp_valid = 1'b0;
    check_vec("st_resp_no_accept", req_ready, 0);
    check_vec("st_resp_valid", resp_valid, 3'b001);
    resp_ready = 3'b001;
    tick();
    resp_ready = '0;
    check_vec("st_host1_accept", req_ready, 3'b010);

    // Host 1 aborts in WAIT; late response drained in IDLE.
    tick();
    req_valid = '0;
    check_vec("ab_grant", grant_id, 1);
    dmi_req_ready = 1'b1;
    tick();
    dmi_req_ready = 1'b0;
    host_clear = 3'b010;
    tick();
    host_clear = '0;
    check_vec("ab_clear_pulse", dmi_clear, 1);
    check_vec("ab_no_resp", resp_valid, 0);
    dmi_resp_valid = 1'b1;
    dmi_resp_data = 32'hBAD0BAD0;
    #1;
    check_vec("ab_drain_ready", dmi_resp_ready, 1);
    tick();
    dmi_resp_valid = 1'b0;
    check_vec("ab_clear_single", dmi_clear, 0);
    check_vec("ab_still_no_resp", resp_valid, 0);

    // Timeout; pointer still 1 after abort, so host 1 beats host 2.
    req_valid = 3'b110;
    req_addr[1*AW +: AW] = 7'h22;
    #1;
    check_vec("to_ptr_kept", req_ready, 3'b010);
    tick();
    req_valid = '0;
    dmi_req_ready = 1'b1;
    tick();
    dmi_req_ready = 1'b0;
    dmi_resp_data = 32'h55555555;
    for (int c = 1; c < 8; c++) begin
      tick();
      check_vec("to_not_yet", {timeout, dmi_clear, resp_valid}, 0);
    end
    tick();
    check_vec("to_timeout", timeout, 1);
    check_vec("to_clear", dmi_clear, 1);
    check_vec("to_resp_valid", resp_valid, 3'b010);
    check_vec("to_resp", {resp_code, resp_data}, {2'd2, 32'h0});
    tick();
    check_vec("to_pulse_end", {timeout, dmi_clear}, 0);
    resp_ready = 3'b010;
    tick();
    resp_ready = '0;

    // Reset while host 2 is in RESP.
    req_valid = 3'b100;
    tick();
    req_valid = '0;
    dmi_req_ready = 1'b1;
    tick();
    dmi_req_ready = 1'b0;
    dmi_resp_valid = 1'b1;
    dmi_resp_data = 32'hDEAD0002;
    tick();
    dmi_resp_valid = 1'b0;
    check_vec("rr_resp_host2", resp_valid, 3'b100);
    rst = 1'b1;
    #1;
    check_vec("rr_outputs_zero", {resp_valid, resp_data, grant_id, dmi_req_valid, dmi_resp_ready}, 0);
    tick();
    rst = 1'b0;
    tick();

    // Round robin with all hosts valid: 0,1,2,0,1,2.
    req_addr = {7'h22, 7'h21, 7'h20};
    for (int t = 0; t < 6; t++) begin
      req_valid = 3'b111;
      #1;
      check_vec("rr_accept", req_ready, 3'b001 << (t % 3));
      tick();
      check_vec("rr_grant", grant_id, t % 3);
      check_vec("rr_addr", dmi_req_addr, 7'h20 + (t % 3));
      dmi_req_ready = 1'b1;
      tick();
      dmi_req_ready = 1'b0;
      dmi_resp_valid = 1'b1;
      dmi_resp_data = 32'h100 + t;
      tick();
      dmi_resp_valid = 1'b0;
      check_vec("rr_resp_route", resp_valid, 3'b001 << (t % 3));
      check_vec("rr_resp_data", resp_data, 32'h100 + t);
      resp_ready = 3'b111;
      tick();
      resp_ready = '0;
    end
    req_valid = '0;

    // Several clears at once in IDLE give one pulse.
    host_clear = 3'b111;
    tick();
    host_clear = '0;
    check_vec("mc_pulse", dmi_clear, 1);
    tick();
    check_vec("mc_single", dmi_clear, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
    $finish;
  end

endmodule
